// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall service unit: service codes and FSM states.
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_STRING = 32'd4;
  localparam logic [31:0] SYS_EXIT         = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR   = 32'd11;
  localparam logic [31:0] SYS_PRINT_HEX    = 32'd34;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHAR     = 3'd1,
    HEX      = 3'd2,
    STR_REQ  = 3'd3,
    STR_WAIT = 3'd4,
    STR_EMIT = 3'd5,
    EXIT     = 3'd6,
    FIN      = 3'd7
  } state_e;

endpackage

// File: rtl/syscall_unit_if.sv
// Bundle of core, data-memory read port and console signals around syscall_unit.
interface syscall_unit_if;
  import syscall_pkg::*;

  // Core side: syscall_valid pulses once on a decoded SYSCALL; stall/done/halt/bad_code report back.
  logic        syscall_valid;
  logic [31:0] sys_call_reg;
  logic [31:0] std_out_address;
  logic        stall;
  logic        done;
  logic        halt;
  logic        bad_code;

  // Memory read port: mem_rd_data is valid exactly one cycle after mem_rd_en.
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;

  // Console: a byte transfers on a cycle with out_valid & out_ready. Once out_valid rises it stays
  // high with out_byte unchanged until that transfer happens; only reset may drop it early.
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_ready;

  state_e      dbg_state;

  modport slave (
    input  syscall_valid, sys_call_reg, std_out_address, mem_rd_data, out_ready,
    output stall, done, halt, bad_code, mem_rd_en, mem_addr, out_valid, out_byte, dbg_state
  );

  modport master (
    output syscall_valid, sys_call_reg, std_out_address, mem_rd_data, out_ready,
    input  stall, done, halt, bad_code, mem_rd_en, mem_addr, out_valid, out_byte, dbg_state
  );

endinterface

// File: rtl/syscall_unit_hex_ascii.sv
// Converts one 4-bit nibble to its uppercase ASCII hex digit.
module hex_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    if (nibble < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble};
    end else begin
      ascii = 8'h41 + ({4'h0, nibble} - 8'd10);
    end
  end

endmodule

// File: rtl/syscall_unit.sv
// Services MIPS SYSCALLs (print char/hex/string, exit): streams ASCII to a console
// and holds the core stalled while a service is in progress.
module syscall_unit
  import syscall_pkg::*;
#(
  parameter int MAX_STR_LEN = 256,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  syscall_unit_if.slave  bus
);

  localparam int LEN_W = $clog2(MAX_STR_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_STR_LEN - 1);

  state_e           state_q, state_d;
  logic [31:0]      arg_q, arg_d;
  logic [31:0]      ptr_q, ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]       digit_q, digit_d;
  logic [7:0]       byte_q, byte_d;
  logic             halt_q, halt_d;

  logic             accept;
  logic [2:0]       nib_sel;
  logic [3:0]       nibble;
  logic [7:0]       hex_char;
  logic [1:0]       lane;
  logic [7:0]       rd_byte;

  logic             out_valid;
  logic [7:0]       out_byte;
  logic             mem_rd_en;
  logic [31:0]      mem_addr;
  logic             done;
  logic             bad_code;

  assign accept = bus.syscall_valid && (state_q == IDLE) && !halt_q;

  // Digit 0 is the most significant nibble.
  assign nib_sel = 3'd7 - digit_q;
  assign nibble  = arg_q[{nib_sel, 2'b00} +: 4];

  hex_ascii u_hex_ascii (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  // Big-endian puts addr[1:0]=0 in bits 31:24, so the lane index is inverted.
  assign lane    = BIG_ENDIAN ? ~ptr_q[1:0] : ptr_q[1:0];
  assign rd_byte = bus.mem_rd_data[{lane, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    arg_d     = arg_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    digit_d   = digit_q;
    byte_d    = byte_q;
    halt_d    = halt_q;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    mem_rd_en = 1'b0;
    mem_addr  = 32'h0;
    done      = 1'b0;
    bad_code  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          arg_d   = bus.std_out_address;
          ptr_d   = bus.std_out_address;
          len_d   = '0;
          digit_d = 3'd0;
          case (bus.sys_call_reg)
            SYS_PRINT_CHAR:   state_d = CHAR;
            SYS_PRINT_HEX:    state_d = HEX;
            SYS_PRINT_STRING: state_d = STR_REQ;
            SYS_EXIT:         state_d = EXIT;
            default: begin
              // Unsupported code completes in the accept cycle itself.
              bad_code = 1'b1;
              done     = 1'b1;
            end
          endcase
        end
      end

      CHAR: begin
        out_valid = 1'b1;
        out_byte  = arg_q[7:0];
        if (bus.out_ready) begin
          state_d = FIN;
        end
      end

      HEX: begin
        out_valid = 1'b1;
        out_byte  = hex_char;
        if (bus.out_ready) begin
          digit_d = digit_q + 3'd1;
          if (digit_q == 3'd7) begin
            state_d = FIN;
          end
        end
      end

      STR_REQ: begin
        mem_rd_en = 1'b1;
        mem_addr  = {ptr_q[31:2], 2'b00};
        state_d   = STR_WAIT;
      end

      STR_WAIT: begin
        if (rd_byte == 8'h00) begin
          state_d = FIN;
        end else begin
          byte_d  = rd_byte;
          state_d = STR_EMIT;
        end
      end

      STR_EMIT: begin
        out_valid = 1'b1;
        out_byte  = byte_q;
        if (bus.out_ready) begin
          ptr_d = ptr_q + 32'd1;
          len_d = len_q + LEN_W'(1);
          // Every byte re-reads its word; simpler than tracking word reuse.
          if (len_q == LEN_LAST) begin
            state_d = FIN;
          end else begin
            state_d = STR_REQ;
          end
        end
      end

      EXIT: begin
        halt_d  = 1'b1;
        state_d = FIN;
      end

      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      arg_q   <= 32'h0;
      ptr_q   <= 32'h0;
      len_q   <= '0;
      digit_q <= 3'd0;
      byte_q  <= 8'h00;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arg_q   <= arg_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      digit_q <= digit_d;
      byte_q  <= byte_d;
      halt_q  <= halt_d;
    end
  end

  assign bus.stall     = (state_q != IDLE) || accept;
  assign bus.done      = done;
  assign bus.halt      = halt_q;
  assign bus.bad_code  = bad_code;
  assign bus.mem_rd_en = mem_rd_en;
  assign bus.mem_addr  = mem_addr;
  assign bus.out_valid = out_valid;
  assign bus.out_byte  = out_byte;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: byte-addressed memory, console sink with selectable backpressure,
// and a reference model that derives the expected byte/read streams from each syscall.
module tb_syscall_unit;
  import syscall_pkg::*;

  localparam int MAXLEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  syscall_unit_if bus();

  syscall_unit #(.MAX_STR_LEN(MAXLEN), .BIG_ENDIAN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_reads  = 0;
  int ready_mode = 0;
  bit halt_m = 1'b0;

  logic [7:0]  exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  mem_b [logic [31:0]];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] got);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected value 0x%0h with nothing expected", name, got);
  endtask

  function automatic logic [7:0] getb(input logic [31:0] a);
    return mem_b.exists(a) ? mem_b[a] : 8'h00;
  endfunction

  // Reference model: returns 1 for an unsupported code, queues expected bytes and read addresses.
  function automatic bit model_call(input logic [31:0] code, input logic [31:0] arg);
    string hexd = "0123456789ABCDEF";
    logic [31:0] p;
    case (code)
      32'd11: exp_q.push_back(arg[7:0]);
      32'd34: for (int i = 7; i >= 0; i--) exp_q.push_back(hexd[arg[4*i +: 4]]);
      32'd4: begin
        p = arg;
        for (int n = 0; n < MAXLEN; n++) begin
          exp_addr_q.push_back({p[31:2], 2'b00});
          if (getb(p) == 8'h00) break;
          exp_q.push_back(getb(p));
          p = p + 32'd1;
        end
      end
      32'd10: halt_m = 1'b1;
      default: return 1'b1;
    endcase
    return 1'b0;
  endfunction

  // Memory: sample request at negedge, present the big-endian word one cycle later.
  initial begin
    bus.mem_rd_data = 32'h0;
    forever begin
      logic        req;
      logic [31:0] a;
      @(negedge clk);
      req = bus.mem_rd_en;
      a   = bus.mem_addr;
      @(posedge clk);
      #1;
      bus.mem_rd_data = req ? {getb(a), getb(a + 32'd1), getb(a + 32'd2), getb(a + 32'd3)}
                            : $urandom;
    end
  end

  // Console sink backpressure.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ~bus.out_ready;
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: console bytes, handshake stability and read addresses every cycle.
  initial begin
    bit         pv;
    logic [7:0] pb;
    pv = 1'b0;
    pb = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_byte", bus.out_byte, pb);
        end
        if (bus.out_valid && bus.out_ready) begin
          got_q.push_back(bus.out_byte);
          if (exp_q.size() == 0) note_fail("extra_byte", bus.out_byte);
          else check("out_byte", bus.out_byte, exp_q.pop_front());
        end
        pv = bus.out_valid && !bus.out_ready;
        pb = bus.out_byte;
        if (bus.mem_rd_en) begin
          n_reads++;
          if (exp_addr_q.size() == 0) note_fail("extra_read", bus.mem_addr);
          else check("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
        end
      end
    end
  end

  task automatic run_call(input logic [31:0] code, input logic [31:0] arg, input bit exp_accept,
                          output int done_cyc, output int stalls);
    bit exp_bad;
    bit got_done;
    bit got_bad;
    int cyc;
    int limit;
    exp_bad = exp_accept ? model_call(code, arg) : 1'b0;
    got_q.delete();
    n_reads = 0;
    done_cyc = -1;
    @(posedge clk);
    #1;
    bus.syscall_valid   = 1'b1;
    bus.sys_call_reg    = code;
    bus.std_out_address = arg;
    @(negedge clk);
    check("accept_stall", bus.stall, exp_accept);
    got_done = bus.done;
    got_bad  = bus.bad_code;
    stalls   = bus.stall ? 1 : 0;
    if (got_done) done_cyc = 0;
    @(posedge clk);
    #1;
    bus.syscall_valid   = 1'b0;
    bus.sys_call_reg    = $urandom;
    bus.std_out_address = $urandom;
    cyc = 0;
    limit = exp_accept ? 400 : 10;
    while ((!got_done || !exp_accept) && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (bus.done && !got_done) done_cyc = cyc;
      got_done = got_done | bus.done;
      got_bad  = got_bad | bus.bad_code;
      stalls  += bus.stall ? 1 : 0;
    end
    if (exp_accept) begin
      check("done_seen", got_done, 1);
      check("bad_code", got_bad, exp_bad);
      check("halt", bus.halt, halt_m);
      check("bytes_left", exp_q.size(), 0);
      check("reads_left", exp_addr_q.size(), 0);
      @(negedge clk);
      check("idle_stall", bus.stall, 0);
    end else begin
      check("ignored_done", got_done, 0);
      check("ignored_stall", stalls, 0);
      check("ignored_bytes", got_q.size(), 0);
    end
  endtask

  task automatic check_bytes(input string name, input logic [63:0] lit, input int n);
    check({name, "_len"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check(name, got_q[i], lit[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic put_str(input logic [31:0] base, input string s);
    for (int i = 0; i < s.len(); i++) mem_b[base + i] = s[i];
    mem_b[base + s.len()] = 8'h00;
  endtask

  initial begin
    int dc;
    int st;
    int r;
    int seen;
    logic [31:0] base;
    bus.syscall_valid   = 1'b0;
    bus.sys_call_reg    = 32'h0;
    bus.std_out_address = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_done", bus.done, 0);
    check("rst_halt", bus.halt, 0);
    check("rst_bad_code", bus.bad_code, 0);
    check("rst_mem_rd_en", bus.mem_rd_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    mem_b[32'h1000] = 8'h48;
    mem_b[32'h1001] = 8'h69;
    mem_b[32'h1002] = 8'h0A;
    mem_b[32'h1003] = 8'h00;
    put_str(32'h1100, "ABCDEF");

    ready_mode = 0;
    run_call(32'd11, 32'h0000_0041, 1'b1, dc, st);
    check("char_done_latency", dc, 2);
    check("char_stall_cycles", st, 3);
    check_bytes("char_bytes", 64'h41, 1);

    ready_mode = 1;
    run_call(32'd34, 32'hDEAD_BEEF, 1'b1, dc, st);
    check_bytes("hex_bytes", 64'h4445_4144_4245_4546, 8);

    ready_mode = 0;
    run_call(32'd4, 32'h0000_1001, 1'b1, dc, st);
    check_bytes("str_unaligned", 64'h690A, 2);
    check("str_unaligned_reads", n_reads, 3);

    ready_mode = 2;
    run_call(32'd4, 32'h0000_1100, 1'b1, dc, st);
    check_bytes("str_cap", 64'h4142_4344, 4);
    check("str_cap_reads", n_reads, 4);

    ready_mode = 0;
    run_call(32'd99, $urandom, 1'b1, dc, st);
    check("bad_done_latency", dc, 0);
    check("bad_bytes", got_q.size(), 0);

    for (int k = 0; k < 40; k++) begin
      ready_mode = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        run_call(32'd11, $urandom, 1'b1, dc, st);
      end else if (r <= 5) begin
        run_call(32'd34, $urandom, 1'b1, dc, st);
      end else if (r <= 8) begin
        base = 32'h2000 + $urandom_range(0, 255);
        for (int j = 0; j < 8; j++) mem_b[base + j] = 8'($urandom_range(1, 255));
        mem_b[base + $urandom_range(0, 6)] = 8'h00;
        run_call(32'd4, base, 1'b1, dc, st);
      end else begin
        run_call($urandom_range(12, 33), $urandom, 1'b1, dc, st);
      end
    end

    // Reset while a string byte is waiting on a stalled console.
    put_str(32'h3000, "HELLOWORLD");
    ready_mode = 3;
    got_q.delete();
    void'(model_call(32'd4, 32'h3000));
    @(posedge clk);
    #1;
    bus.syscall_valid   = 1'b1;
    bus.sys_call_reg    = 32'd4;
    bus.std_out_address = 32'h3000;
    @(posedge clk);
    #1;
    bus.syscall_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("rst_mid_emit_reached", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_stall", bus.stall, 0);
    check("rst_mid_mem_rd_en", bus.mem_rd_en, 0);
    check("rst_mid_done", bus.done, 0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_mode = 0;

    run_call(32'd11, 32'h0000_005A, 1'b1, dc, st);
    check("post_rst_char_latency", dc, 2);
    check_bytes("post_rst_char", 64'h5A, 1);

    run_call(32'd10, 32'h0, 1'b1, dc, st);
    check("exit_halt", bus.halt, 1);
    check("exit_bytes", got_q.size(), 0);

    run_call(32'd11, 32'h0000_0041, 1'b0, dc, st);
    check("halt_sticky", bus.halt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Services MIPS SYSCALL instructions on behalf of the core.
- Consumes the register file's syscall code ($v0, sys_call_reg) and argument ($a0, std_out_address), and streams ASCII bytes to a console sink over a valid/ready handshake.
- Holds the pipeline stalled while a service runs.
- Reads string bytes through a dedicated 1-cycle-latency word read port into data memory.

Parameters:
- MAX_STR_LEN, 256: maximum bytes emitted by print_string before forced termination.
- BIG_ENDIAN, 1: byte-lane order within a memory word. 1: byte at addr[1:0]=0 is bits 31:24. 0: it is bits 7:0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- syscall_valid  in  1  one-cycle pulse, SYSCALL decoded this cycle
- sys_call_reg  in  32  $v0, service code
- std_out_address  in  32  $a0, argument (value, char or string address)
- mem_rd_en  out  1  memory read request
- mem_addr  out  32  word-aligned read address, [1:0]=0
- mem_rd_data  in  32  read data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  console byte valid
- out_byte  out  8  console ASCII byte
- out_ready  in  1  console accepts byte when out_valid & out_ready
- stall  out  1  freeze the core pipeline
- done  out  1  one-cycle pulse, service complete
- halt  out  1  sticky, exit service executed
- bad_code  out  1  one-cycle pulse, unsupported code

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, mem_addr=0, counters 0.
- Accept:
  - In IDLE with syscall_valid=1 and halt=0, latch code=sys_call_reg and arg=std_out_address on that clk edge.
  - stall is combinational: high when syscall_valid & IDLE & !halt, and in every non-IDLE state.
  - stall falls in the cycle the FSM re-enters IDLE.
- Codes:
  - 11 print_char -> CHAR.
  - 34 print_hex -> HEX.
  - 4 print_string -> STR_REQ.
  - 10 exit -> EXIT.
  - Any other code -> IDLE next cycle, with bad_code and done pulsed that cycle; no bytes emitted.
- CHAR: out_valid=1, out_byte=arg[7:0]. On handshake -> FIN.
- HEX:
  - Emits 8 bytes, most-significant nibble first.
  - Nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+(n-10), uppercase.
  - A 3-bit digit counter advances only on handshake. The 8th handshake -> FIN.
- STR_REQ: mem_rd_en=1 for exactly 1 cycle, mem_addr={ptr[31:2],2'b00}; ptr initialised to arg -> STR_WAIT.
- STR_WAIT: capture the byte selected by ptr[1:0] per BIG_ENDIAN.
  - Byte == 0x00 -> FIN; nothing emitted.
  - Otherwise -> STR_EMIT.
- STR_EMIT: out_valid=1 with the captured byte. On handshake: ptr+=1 (32-bit wrap), len+=1.
  - If len reaches MAX_STR_LEN -> FIN.
  - Otherwise -> STR_REQ.
  - Each byte costs one read; word reuse is not required.
- EXIT: set halt=1 -> FIN. halt stays set until reset; later syscall_valid is ignored and stall stays 0.
- FIN: done=1 for 1 cycle, stall=1 -> IDLE.
- Handshake rules:
  - out_byte is stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake, except on reset.
- syscall_valid is ignored in non-IDLE states; the core is stalled, so none arrive.
- Reset mid-service abandons it immediately; no partial done pulse.

Decomposition:
- Package syscall_pkg holds:
  - Service code constants: SYS_PRINT_STRING=4, SYS_EXIT=10, SYS_PRINT_CHAR=11, SYS_PRINT_HEX=34.
  - The state enumeration: IDLE, CHAR, HEX, STR_REQ, STR_WAIT, STR_EMIT, EXIT, FIN.
- One combinational sub-module, hex_ascii: 4-bit nibble -> 8-bit ASCII.
- Byte-lane selection stays inline.

Test Plan:
- print_char: v0=11, a0=0x00000041, out_ready=1 -> one byte 0x41. done 2 cycles after accept; stall high 3 cycles total.
- print_hex with backpressure: v0=34, a0=0xDEADBEEF, out_ready toggling 1/0 -> "DEADBEEF" (0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46). out_byte holds while out_ready=0; exactly 8 handshakes.
- print_string, unaligned: memory word 0x1000 = 0x48690A00, v0=4, a0=0x1001, BIG_ENDIAN=1 -> bytes 0x69, 0x0A, then terminate on 0x00. mem_addr always 0x1000.
- Length cap: MAX_STR_LEN=4, string "ABCDEF\0" -> exactly "ABCD", then done.
- Exit and bad code:
  - v0=10 -> halt=1 and done pulse; a subsequent syscall_valid gives no stall or output.
  - v0=99 (after reset) -> bad_code and done in the same cycle, no out_valid.
- Reset mid-string: rst_n low during STR_EMIT -> out_valid, stall and mem_rd_en at 0 immediately. After release, IDLE accepts a new print_char normally.
